// File: rtl/dma_mem_responder.sv
// rtl/dma_mem_responder.sv - DMA memory responder: protect window, sticky errors, saturating counters (optional DMA_MEM_PARITY_EN)
module dma_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read_en,
  input  logic                  mem_write_en,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  input  logic                  host_inj_perr,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_collision,
  input  logic                  prot_en,
  input  logic [ADDR_WIDTH-1:0] prot_lo,
  input  logic [ADDR_WIDTH-1:0] prot_hi,
  input  logic                  err_clr,
  output logic                  prot_err,
  output logic                  range_err,
  output logic                  rw_conflict,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic                  parity_err
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic dma_in_range, host_in_range, prot_hit, wr_accept, host_wr, collide;
  logic prot_ev, range_ev, conf_ev, any_ev;
  logic err_held;  // err_addr already holds the first error since reset/clear

  assign dma_in_range  = 32'(mem_addr) < 32'(MEM_DEPTH);
  assign host_in_range = 32'(host_addr) < 32'(MEM_DEPTH);
  // An inverted window (lo > hi) naturally matches no address
  assign prot_hit      = prot_en && (prot_lo <= mem_addr) && (mem_addr <= prot_hi);
  assign wr_accept     = mem_write_en && dma_in_range && !prot_hit;
  assign host_wr       = host_we && host_in_range;
  assign collide       = host_wr && wr_accept && (host_addr == mem_addr);

  assign prot_ev  = mem_write_en && dma_in_range && prot_hit;
  assign range_ev = (mem_read_en || mem_write_en) && !dma_in_range;
  assign conf_ev  = mem_read_en && mem_write_en;
  assign any_ev   = prot_ev || range_ev || conf_ev;

  // Zero-latency DMA read of the contents as of the last edge
  assign mem_read_data = (mem_read_en && dma_in_range) ? mem[mem_addr] : '0;

  // Storage array and host port; DMA write is applied last so it wins a collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      host_rdata     <= '0;
      host_collision <= 1'b0;
    end else begin
      host_rdata     <= host_in_range ? mem[host_addr] : '0;
      host_collision <= collide;
      if (host_wr && !collide) mem[host_addr] <= host_wdata;
      if (wr_accept) mem[mem_addr] <= mem_write_data;
    end
  end

`ifdef DMA_MEM_PARITY_EN
  logic par [MEM_DEPTH];
  logic par_bad;

  assign par_bad = mem_read_en && dma_in_range && ((^mem[mem_addr]) != par[mem_addr]);

  // Even-parity shadow bits plus sticky mismatch flag; a new mismatch beats err_clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) par[i] <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= (parity_err && !err_clr) || par_bad;
      if (host_wr && !collide) par[host_addr] <= (^host_wdata) ^ host_inj_perr;
      if (wr_accept) par[mem_addr] <= ^mem_write_data;
    end
  end
`else
  logic unused_inj_perr;
  assign unused_inj_perr = host_inj_perr;
  assign parity_err      = 1'b0;
`endif

  // Sticky error flags and first-error address; a same-cycle error beats err_clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prot_err    <= 1'b0;
      range_err   <= 1'b0;
      rw_conflict <= 1'b0;
      err_held    <= 1'b0;
      err_addr    <= '0;
    end else begin
      prot_err    <= (prot_err && !err_clr) || prot_ev;
      range_err   <= (range_err && !err_clr) || range_ev;
      rw_conflict <= (rw_conflict && !err_clr) || conf_ev;
      err_held    <= (err_held && !err_clr) || any_ev;
      if (any_ev && (!err_held || err_clr)) err_addr <= mem_addr;
      else if (err_clr)                     err_addr <= '0;
    end
  end

  // Saturating activity counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (mem_read_en && (rd_count != '1)) rd_count <= rd_count + CNT_WIDTH'(1);
      if (wr_accept && (wr_count != '1))   wr_count <= wr_count + CNT_WIDTH'(1);
    end
  end

endmodule
